// File: rtl/btb_pkg.sv
// Shared encodings and PC field helpers for the branch target buffer.
package btb_pkg;

  localparam logic [1:0] CTR_SNT   = 2'b00;
  localparam logic [1:0] CTR_WNT   = 2'b01;
  localparam logic [1:0] CTR_WT    = 2'b10;
  localparam logic [1:0] CTR_ST    = 2'b11;
  localparam logic [1:0] CTR_RESET = CTR_WNT;
  localparam logic [1:0] CTR_ALLOC = CTR_WT;

  // Helpers return full-width words; callers slice to their IDX_W / tag width.
  function automatic logic [31:0] pc_idx(input logic [31:0] pc, input int idx_w);
    logic [31:0] mask;
    mask = (32'd1 << idx_w) - 32'd1;
    return (pc >> 2) & mask;
  endfunction

  function automatic logic [31:0] pc_tag(input logic [31:0] pc, input int idx_w);
    return pc >> (idx_w + 2);
  endfunction

endpackage

// File: rtl/btb_predictor_if.sv
// Fetch-lookup and branch-training bus between the pipeline and the BTB.
interface btb_if;
  logic [31:0] fetch_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispredict;
  logic        btb_clear;
  logic [15:0] mispred_cnt;

  modport master (
    output fetch_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict, btb_clear,
    input  pred_taken, pred_target, mispred_cnt
  );

  modport slave (
    input  fetch_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict, btb_clear,
    output pred_taken, pred_target, mispred_cnt
  );
endinterface

// File: rtl/btb_predictor_sat_ctr2.sv
// 2-bit saturating direction counter next-state function.
module sat_ctr2
  import btb_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] ctr_nxt
);

  always_comb begin
    ctr_nxt = ctr;
    if (taken) begin
      if (ctr != CTR_ST) ctr_nxt = ctr + 2'd1;
    end else begin
      if (ctr != CTR_SNT) ctr_nxt = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped BTB: combinational lookup on fetch_pc, trained on the gated PC clock.
module btb_predictor
  import btb_pkg::*;
#(
  parameter int ENTRIES = 16
) (
  input logic  gated_clock_PC,
  input logic  rst,
  btb_if.slave bus
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic [ENTRIES-1:0]             valid_q;
  logic [ENTRIES-1:0][TAG_W-1:0]  tag_q;
  logic [ENTRIES-1:0][31:0]       target_q;
  logic [ENTRIES-1:0][1:0]        ctr_q;
  logic [15:0]                    mispred_cnt_q;

  logic [31:0] f_idx_w, f_tag_w, u_idx_w, u_tag_w;
  logic [IDX_W-1:0] f_idx, u_idx;
  logic [TAG_W-1:0] f_tag, u_tag;
  logic f_hit, u_hit;
  logic [1:0] ctr_nxt;
  logic unused_bits;

  assign f_idx_w = pc_idx(bus.fetch_pc, IDX_W);
  assign f_tag_w = pc_tag(bus.fetch_pc, IDX_W);
  assign u_idx_w = pc_idx(bus.upd_pc, IDX_W);
  assign u_tag_w = pc_tag(bus.upd_pc, IDX_W);
  assign f_idx   = f_idx_w[IDX_W-1:0];
  assign f_tag   = f_tag_w[TAG_W-1:0];
  assign u_idx   = u_idx_w[IDX_W-1:0];
  assign u_tag   = u_tag_w[TAG_W-1:0];
  assign unused_bits = ^{f_idx_w[31:IDX_W], f_tag_w[31:TAG_W], u_idx_w[31:IDX_W], u_tag_w[31:TAG_W]};

  // Lookup reads pre-edge state, so a same-index update becomes visible next cycle.
  assign f_hit           = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign u_hit           = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  assign bus.pred_taken  = f_hit & ctr_q[f_idx][1];
  assign bus.pred_target = f_hit ? target_q[f_idx] : 32'd0;
  assign bus.mispred_cnt = mispred_cnt_q;

  sat_ctr2 u_sat_ctr2 (
    .ctr    (ctr_q[u_idx]),
    .taken  (bus.upd_taken),
    .ctr_nxt(ctr_nxt)
  );

  always_ff @(posedge gated_clock_PC or posedge rst) begin
    if (rst) begin
      valid_q       <= '0;
      tag_q         <= '0;
      target_q      <= '0;
      ctr_q         <= {ENTRIES{CTR_RESET}};
      mispred_cnt_q <= '0;
    end else begin
      if (bus.upd_valid && bus.upd_mispredict && (mispred_cnt_q != 16'hFFFF))
        mispred_cnt_q <= mispred_cnt_q + 16'd1;
      // Clear wins over training; only valid bits are dropped.
      if (bus.btb_clear) begin
        valid_q <= '0;
      end else if (bus.upd_valid) begin
        if (u_hit) begin
          ctr_q[u_idx] <= ctr_nxt;
          if (bus.upd_taken) target_q[u_idx] <= bus.upd_target;
        end else if (bus.upd_taken) begin
          valid_q[u_idx]  <= 1'b1;
          tag_q[u_idx]    <= u_tag;
          target_q[u_idx] <= bus.upd_target;
          ctr_q[u_idx]    <= CTR_ALLOC;
        end
      end
    end
  end

endmodule

// File: tb/tb_btb_predictor.sv
// Directed self-checking bench for btb_predictor (ENTRIES=16).
module tb_btb_predictor;

  logic gclk = 1'b0;
  bit   clk_en = 1'b1;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  btb_if bus();

  btb_predictor #(.ENTRIES(16)) dut (
    .gated_clock_PC(gclk),
    .rst           (rst),
    .bus           (bus.slave)
  );

  // Gated clock: stops low when clk_en drops.
  initial forever begin
    #5;
    if (clk_en || gclk) gclk = ~gclk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge gclk);
    #1;
  endtask

  task automatic look(input logic [31:0] pc, input string tag, input logic t, input logic [31:0] tgt);
    bus.fetch_pc = pc;
    #1;
    chk({tag, ".taken"}, {31'd0, bus.pred_taken}, {31'd0, t});
    chk({tag, ".target"}, bus.pred_target, tgt);
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt, input logic mis);
    bus.upd_pc = pc; bus.upd_taken = tk; bus.upd_target = tgt; bus.upd_mispredict = mis;
    bus.upd_valid = 1'b1;
    tick();
    bus.upd_valid = 1'b0; bus.upd_mispredict = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.fetch_pc = 32'h40; bus.upd_valid = 1'b0; bus.upd_pc = '0; bus.upd_taken = 1'b0;
    bus.upd_target = '0; bus.upd_mispredict = 1'b0; bus.btb_clear = 1'b0;
    #1;
    look(32'h40, "reset", 1'b0, 32'h0);
    chk("reset.mispred", {16'd0, bus.mispred_cnt}, 32'd0);
    @(negedge gclk); rst = 1'b0;

    // Allocate, saturate high, walk down, saturate low, retarget.
    upd(32'h40, 1'b1, 32'h100, 1'b0);
    look(32'h40, "alloc", 1'b1, 32'h100);
    repeat (4) upd(32'h40, 1'b1, 32'h100, 1'b0);
    upd(32'h40, 1'b0, 32'h0, 1'b0);
    look(32'h40, "st_nt1", 1'b1, 32'h100);
    upd(32'h40, 1'b0, 32'h0, 1'b0);
    look(32'h40, "wt_nt", 1'b0, 32'h100);
    upd(32'h40, 1'b0, 32'h0, 1'b0);
    look(32'h40, "wnt_nt", 1'b0, 32'h100);
    upd(32'h40, 1'b0, 32'h0, 1'b0);
    upd(32'h40, 1'b1, 32'h0, 1'b0);
    look(32'h40, "snt_sat_t", 1'b0, 32'h0);
    upd(32'h40, 1'b1, 32'h104, 1'b0);
    look(32'h40, "retarget", 1'b1, 32'h104);

    // Aliasing on index 0, low pc bits ignored, not-taken miss allocates nothing.
    upd(32'h80, 1'b1, 32'h200, 1'b0);
    look(32'h80, "alias_new", 1'b1, 32'h200);
    look(32'h40, "alias_old", 1'b0, 32'h0);
    look(32'h83, "lowbits", 1'b1, 32'h200);
    upd(32'h44, 1'b0, 32'h500, 1'b0);
    look(32'h44, "nt_miss", 1'b0, 32'h0);

    // Stall: 0x80 sits at weak-taken; a held not-taken update must land exactly once.
    @(negedge gclk); clk_en = 1'b0;
    bus.upd_pc = 32'h80; bus.upd_taken = 1'b0; bus.upd_target = 32'h0; bus.upd_valid = 1'b1;
    #50;
    look(32'h80, "stall", 1'b1, 32'h200);
    clk_en = 1'b1;
    tick();
    bus.upd_valid = 1'b0;
    look(32'h80, "stall_once", 1'b0, 32'h200);
    upd(32'h80, 1'b1, 32'h200, 1'b0);
    look(32'h80, "stall_after", 1'b1, 32'h200);

    // Clear overrides a same-edge taken update.
    bus.btb_clear = 1'b1;
    bus.upd_pc = 32'h40; bus.upd_taken = 1'b1; bus.upd_target = 32'h300; bus.upd_valid = 1'b1;
    tick();
    bus.btb_clear = 1'b0; bus.upd_valid = 1'b0;
    look(32'h80, "clear_80", 1'b0, 32'h0);
    look(32'h40, "clear_40", 1'b0, 32'h0);

    repeat (5) upd(32'h44, 1'b0, 32'h0, 1'b1);
    chk("mispred5", {16'd0, bus.mispred_cnt}, 32'd5);
    bus.upd_mispredict = 1'b1;
    tick();
    bus.upd_mispredict = 1'b0;
    chk("mispred_novalid", {16'd0, bus.mispred_cnt}, 32'd5);

    // Asynchronous reset with the clock gated off.
    upd(32'h80, 1'b1, 32'h600, 1'b0);
    look(32'h80, "pre_rst", 1'b1, 32'h600);
    @(negedge gclk); clk_en = 1'b0;
    #2; rst = 1'b1;
    #1;
    chk("rst.mispred", {16'd0, bus.mispred_cnt}, 32'd0);
    look(32'h80, "rst", 1'b0, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/btb_predictor.md
# btb_predictor

Direct-mapped branch target buffer that supplies the fetch stage's next-PC redirect (`pred_taken`, `pred_target`) from the current fetch PC, and is trained by branch outcomes resolved downstream. It sits beside the PC register, on the same gated clock, so its table advances only when the PC advances. Stalled cycles never train or disturb it. Each entry holds a valid bit, a tag, a 32-bit target and a 2-bit saturating direction counter.

## Interface
- `ENTRIES`, 16: table depth; power of two, 4..256.
- `IDX_W`, log2(`ENTRIES`): index width, derived and not overridden.
- `gated_clock_PC`  in  1  clock; rst is asynchronous, active-high.
- `rst`  in  1  asynchronous active-high reset.
- `fetch_pc`  in  32  PC currently presented to instruction memory.
- `pred_taken`  out  1  hit and counter predicts taken.
- `pred_target`  out  32  stored target on hit, else 0.
- `upd_valid`  in  1  a resolved branch is presented for training.
- `upd_pc`  in  32  PC of the resolved branch.
- `upd_taken`  in  1  actual direction.
- `upd_target`  in  32  actual taken target.
- `upd_mispredict`  in  1  the branch was mispredicted (statistics only).
- `btb_clear`  in  1  synchronous invalidate of all entries (e.g. on `fence.i`).
- `mispred_cnt`  out  16  saturating count of trained mispredictions.

## Operation
- Index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]; pc[1:0] are ignored on both ports.
- Lookup is combinational from `fetch_pc` and the stored state.
  - Hit = valid[idx] and tag[idx] equal the fetch tag.
  - `pred_taken` = hit and ctr[idx][1]. `pred_target` = hit ? target[idx] : 0.
- Counter encoding: 00 strong-not-taken, 01 weak-not-taken, 10 weak-taken, 11 strong-taken.
- Training is sampled on each rising edge of `gated_clock_PC` with `upd_valid`=1:
  - Tag hit, taken: ctr increments, saturating at 11; target is overwritten with `upd_target`.
  - Tag hit, not taken: ctr decrements, saturating at 00; target is unchanged.
  - Miss, taken: the entry is allocated or replaced: valid=1, new tag, target = `upd_target`, ctr=10.
  - Miss, not taken: no change.
- `mispred_cnt` increments on a sampled edge with `upd_valid` and `upd_mispredict` both 1, and saturates at 0xFFFF.
- `btb_clear` at an edge clears every valid bit and overrides any update at the same edge. Counters, targets and `mispred_cnt` are not cleared.
- Producer rule: the update source must hold `upd_*` stable until a `gated_clock_PC` edge occurs. Updates presented only while the clock is gated off are lost by design.

## Timing
- Reset: all valid=0, all ctr=01, targets=0, `mispred_cnt`=0. Consequently `pred_taken`=0 and `pred_target`=0 immediately, with no clock required.
- Lookup latency is zero (same cycle as `fetch_pc`). Training latency is one edge: the result is visible to lookup after the sampling edge.
- Lookup and update to the same index at the same edge: lookup returns the pre-edge contents.
- `rst` mid-training discards the in-flight update. Its assertion and release are independent of the clock gating.
- No gated edge means no state change of any kind.

## Structure
- Package `btb_pkg` holds:
  - counter encodings `CTR_SNT`/`CTR_WNT`/`CTR_WT`/`CTR_ST`;
  - the reset counter value `CTR_RESET`=`CTR_WNT` and the allocate value `CTR_ALLOC`=`CTR_WT`;
  - functions for index and tag extraction.
- One sub-module, `sat_ctr2`: a combinational 2-bit saturating next-state function with inputs ctr and taken. It is instantiated once on the update path.
- Table storage is flat register arrays (valid, tag, target, ctr) in the top module. There is no RAM macro, because lookup is asynchronous read.

## Test plan
- Reset, then `fetch_pc`=0x40 -> `pred_taken`=0, `pred_target`=0, `mispred_cnt`=0.
- Update pc=0x40, taken, target=0x100, one edge; then `fetch_pc`=0x40 -> `pred_taken`=1, `pred_target`=0x100 (ctr 10). Four further taken updates -> ctr stays 11.
- From ctr 10 at 0x40, two not-taken updates -> `pred_taken`=0 after the first (01) and after the second (00). The target stays 0x100.
- Aliasing with `ENTRIES`=16:
  - 0x40 trained taken, then 0x80 taken with target 0x200 (same index 0, different tag).
  - `fetch_pc`=0x80 -> hit, `pred_target`=0x200.
  - `fetch_pc`=0x40 -> miss, outputs 0.
- Stall: hold the clock low for 5 cycles with `upd_valid`=1 -> table unchanged. On the first edge the update is applied exactly once (ctr advances one step).
- `btb_clear` and a taken update at the same edge -> every lookup misses afterwards. Five updates with `upd_mispredict`=1 -> `mispred_cnt`=5. Asserting `rst` -> `mispred_cnt`=0 and all lookups miss without a clock.
